// File: rtl/multi_digit_updown_counter_if.sv
// Button / load / display bundle for the multi-digit up/down counter.
// master drives buttons and load, slave (the counter) drives the display side.
interface multi_digit_updown_counter_if #(
  parameter int DIGITS = 4
);
  logic                  up_btn;
  logic                  down_btn;
  logic                  load;
  logic [4*DIGITS-1:0]   load_value;
  logic [4*DIGITS-1:0]   count_out;
  logic [7*DIGITS-1:0]   seg;
  logic                  limit_pulse;

  modport master (
    output up_btn, down_btn, load, load_value,
    input  count_out, seg, limit_pulse
  );

  modport slave (
    input  up_btn, down_btn, load, load_value,
    output count_out, seg, limit_pulse
  );
endinterface

// File: rtl/multi_digit_updown_counter.sv
// Multi-digit hex/BCD up/down counter with button conditioning and
// active-low 7-segment outputs (gfedcba, one group of 7 per digit).

// One button: 2-flop synchroniser, level debouncer, rising-edge step pulse.
module mdc_btn #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic CLK_50,
  input  logic reset,
  input  logic btn,
  output logic step
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_pipe;   // [0] = s1, [1] = s2
  logic          stable;
  logic          stable_d;
  logic [CW-1:0] cnt;

  // synchronise, then accept s2 only after it differs from stable long enough
  always_ff @(posedge CLK_50) begin
    if (reset) begin
      sync_pipe <= '0;
      stable    <= 1'b0;
      stable_d  <= 1'b0;
      cnt       <= '0;
    end else begin
      sync_pipe <= {sync_pipe[0], btn};
      stable_d  <= stable;
      if (sync_pipe[1] == stable) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        stable <= sync_pipe[1];
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // release (1->0) produces no step
  assign step = stable & ~stable_d;
endmodule

// One digit: increment/decrement with ripple carry/borrow, load clamp, segment decode.
module mdc_digit #(
  parameter int DECIMAL = 0
) (
  input  logic [3:0] cur,
  input  logic [3:0] ld_raw,
  input  logic       ci,
  input  logic       bi,
  output logic [3:0] inc_d,
  output logic       co,
  output logic [3:0] dec_d,
  output logic       bo,
  output logic [3:0] ld_d,
  output logic [6:0] seg
);
  localparam logic [3:0] DMAX = (DECIMAL != 0) ? 4'd9 : 4'd15;

  // carry/borrow chain: a digit only moves when everything below it rolled over
  always_comb begin
    inc_d = cur;
    co    = 1'b0;
    dec_d = cur;
    bo    = 1'b0;
    if (ci) begin
      if (cur == DMAX) begin
        inc_d = 4'd0;
        co    = 1'b1;
      end else begin
        inc_d = cur + 4'd1;
      end
    end
    if (bi) begin
      if (cur == 4'd0) begin
        dec_d = DMAX;
        bo    = 1'b1;
      end else begin
        dec_d = cur - 4'd1;
      end
    end
  end

  // BCD counters never hold a nibble above 9, so clamp on the way in
  assign ld_d = ((DECIMAL != 0) && (ld_raw > 4'd9)) ? 4'd9 : ld_raw;

  // active-low segment patterns, bit0 = a
  always_comb begin
    case (cur)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      4'hF:    seg = 7'b0001110;
      default: seg = 7'b0111111;
    endcase
  end
endmodule

module multi_digit_updown_counter #(
  parameter int DIGITS          = 4,
  parameter int DECIMAL         = 0,
  parameter int SATURATE        = 0,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic CLK_50,
  input  logic reset,
  multi_digit_updown_counter_if.slave bus
);
  localparam int W = 4 * DIGITS;

  logic [1:0]              step;   // [0] = up, [1] = down
  logic [W-1:0]            count_q;
  logic [W-1:0]            count_d;
  logic                    limit_q;
  logic                    limit_d;
  logic [DIGITS-1:0][3:0]  cur;
  logic [DIGITS-1:0][3:0]  ld_raw;
  logic [DIGITS-1:0][3:0]  inc_v;
  logic [DIGITS-1:0][3:0]  dec_v;
  logic [DIGITS-1:0][3:0]  ld_v;
  logic [DIGITS-1:0][6:0]  seg_v;
  logic [DIGITS:0]         cy;
  logic [DIGITS:0]         bw;

  mdc_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
    .CLK_50 (CLK_50),
    .reset  (reset),
    .btn    (bus.up_btn),
    .step   (step[0])
  );

  mdc_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dn (
    .CLK_50 (CLK_50),
    .reset  (reset),
    .btn    (bus.down_btn),
    .step   (step[1])
  );

  assign cur    = count_q;
  assign ld_raw = bus.load_value;
  assign cy[0]  = 1'b1;
  assign bw[0]  = 1'b1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    mdc_digit #(.DECIMAL(DECIMAL)) u_dig (
      .cur    (cur[i]),
      .ld_raw (ld_raw[i]),
      .ci     (cy[i]),
      .bi     (bw[i]),
      .inc_d  (inc_v[i]),
      .co     (cy[i+1]),
      .dec_d  (dec_v[i]),
      .bo     (bw[i+1]),
      .ld_d   (ld_v[i]),
      .seg    (seg_v[i])
    );
  end

  // load beats steps; carry/borrow out of the top digit is the limit condition
  always_comb begin
    count_d = count_q;
    limit_d = 1'b0;
    if (bus.load) begin
      count_d = ld_v;
    end else if (step[0] && !step[1]) begin
      limit_d = cy[DIGITS];
      count_d = (cy[DIGITS] && (SATURATE != 0)) ? count_q : inc_v;
    end else if (step[1] && !step[0]) begin
      limit_d = bw[DIGITS];
      count_d = (bw[DIGITS] && (SATURATE != 0)) ? count_q : dec_v;
    end
  end

  // count and limit pulse registers
  always_ff @(posedge CLK_50) begin
    if (reset) begin
      count_q <= '0;
      limit_q <= 1'b0;
    end else begin
      count_q <= count_d;
      limit_q <= limit_d;
    end
  end

  assign bus.count_out   = count_q;
  assign bus.seg         = seg_v;
  assign bus.limit_pulse = limit_q;
endmodule

// File: tb/tb_multi_digit_updown_counter.sv
// Bench for multi_digit_updown_counter: three instances (hex wrap, BCD wrap,
// hex saturate) share one stimulus stream; a scoreboard queue holds the
// expected count/limit per instance with the cycle it becomes due.
module tb_multi_digit_updown_counter;
  localparam int D = 2;

  logic CLK_50 = 1'b0;
  logic reset  = 1'b1;
  always #10 CLK_50 = ~CLK_50;

  logic       up = 1'b0, down = 1'b0, ld = 1'b0;
  logic [7:0] lv = 8'h00;

  multi_digit_updown_counter_if #(.DIGITS(D)) bus0 ();
  multi_digit_updown_counter_if #(.DIGITS(D)) bus1 ();
  multi_digit_updown_counter_if #(.DIGITS(D)) bus2 ();

  assign bus0.up_btn = up;  assign bus0.down_btn = down;  assign bus0.load = ld;  assign bus0.load_value = lv;
  assign bus1.up_btn = up;  assign bus1.down_btn = down;  assign bus1.load = ld;  assign bus1.load_value = lv;
  assign bus2.up_btn = up;  assign bus2.down_btn = down;  assign bus2.load = ld;  assign bus2.load_value = lv;

  multi_digit_updown_counter #(.DIGITS(D), .DECIMAL(0), .SATURATE(0), .DEBOUNCE_CYCLES(4)) dut0 (
    .CLK_50(CLK_50), .reset(reset), .bus(bus0.slave));
  multi_digit_updown_counter #(.DIGITS(D), .DECIMAL(1), .SATURATE(0), .DEBOUNCE_CYCLES(4)) dut1 (
    .CLK_50(CLK_50), .reset(reset), .bus(bus1.slave));
  multi_digit_updown_counter #(.DIGITS(D), .DECIMAL(0), .SATURATE(1), .DEBOUNCE_CYCLES(4)) dut2 (
    .CLK_50(CLK_50), .reset(reset), .bus(bus2.slave));

  logic [2:0][7:0]  act_cnt;
  logic [2:0][13:0] act_seg;
  logic [2:0]       act_lim;
  assign act_cnt = {bus2.count_out, bus1.count_out, bus0.count_out};
  assign act_seg = {bus2.seg, bus1.seg, bus0.seg};
  assign act_lim = {bus2.limit_pulse, bus1.limit_pulse, bus0.limit_pulse};

  localparam logic [6:0] SEG_T [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  typedef struct {
    int              due;
    logic [2:0][7:0] cnt;
    logic [2:0]      lim;
  } exp_t;

  exp_t            q[$];
  logic [7:0]      mcnt [3];
  logic [2:0][7:0] exp_cnt = '0;
  int              cyc = 0;
  int              total = 0;
  int              bad = 0;

  always @(posedge CLK_50) cyc <= cyc + 1;

  task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s dut%0d cyc=%0d got=%0h want=%0h", nm, c, cyc, act, want);
    end
  endtask

  // config 0: hex wrap, 1: BCD wrap, 2: hex saturate -- counts as plain integers
  function automatic logic [8:0] m_step(input int cfg, input logic [7:0] v, input bit is_up);
    int r, mx, n;
    bit lim;
    r   = (cfg == 1) ? 10 : 16;
    mx  = r * r - 1;
    n   = int'(v[7:4]) * r + int'(v[3:0]);
    lim = 1'b0;
    if (is_up) begin
      if (n == mx) begin lim = 1'b1; n = (cfg == 2) ? mx : 0; end
      else n++;
    end else begin
      if (n == 0) begin lim = 1'b1; n = (cfg == 2) ? 0 : mx; end
      else n--;
    end
    return {lim, 4'(n / r), 4'(n % r)};
  endfunction

  function automatic logic [7:0] m_load(input int cfg, input logic [7:0] v);
    logic [7:0] o;
    o = v;
    if (cfg == 1) begin
      if (o[7:4] > 4'd9) o[7:4] = 4'd9;
      if (o[3:0] > 4'd9) o[3:0] = 4'd9;
    end
    return o;
  endfunction

  task automatic commit(input int due, input logic [2:0] lim);
    exp_t e;
    e.due = due;
    e.lim = lim;
    for (int c = 0; c < 3; c++) e.cnt[c] = mcnt[c];
    q.push_back(e);
  endtask

  task automatic apply_step(input bit is_up, output logic [2:0] lim);
    logic [8:0] r;
    for (int c = 0; c < 3; c++) begin
      r       = m_step(c, mcnt[c], is_up);
      mcnt[c] = r[7:0];
      lim[c]  = r[8];
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK_50);
  endtask

  // accepted press: first edge seeing the raw level is cyc+1, count moves 6 edges later
  task automatic press(input bit u, input bit d, input int hold);
    logic [2:0] lim;
    @(negedge CLK_50);
    up = u; down = d;
    lim = '0;
    if (u ^ d) apply_step(u, lim);
    commit(cyc + 7, lim);
    idle(hold);
    up = 1'b0; down = 1'b0;
    idle(12);
  endtask

  task automatic glitch(input bit u, input int hold);
    @(negedge CLK_50);
    if (u) up = 1'b1; else down = 1'b1;
    idle(hold);
    up = 1'b0; down = 1'b0;
    idle(12);
  endtask

  task automatic do_load(input logic [7:0] v);
    @(negedge CLK_50);
    ld = 1'b1; lv = v;
    for (int c = 0; c < 3; c++) mcnt[c] = m_load(c, v);
    commit(cyc + 1, '0);
    @(negedge CLK_50);
    ld = 1'b0;
    idle(2);
  endtask

  // load lands on the same edge the step pulse would have been applied
  task automatic press_load(input bit u, input logic [7:0] v);
    @(negedge CLK_50);
    up = u; down = ~u;
    idle(6);
    ld = 1'b1; lv = v;
    for (int c = 0; c < 3; c++) mcnt[c] = m_load(c, v);
    commit(cyc + 1, '0);
    @(negedge CLK_50);
    ld = 1'b0;
    idle(4);
    up = 1'b0; down = 1'b0;
    idle(12);
  endtask

  task automatic reset_mid(input bit held);
    logic [2:0] lim;
    do_load(8'h57);
    @(negedge CLK_50);
    up = 1'b1;
    idle(2);
    reset = 1'b1;
    for (int c = 0; c < 3; c++) mcnt[c] = 8'h00;
    commit(cyc + 1, '0);
    if (!held) up = 1'b0;
    idle(2);
    reset = 1'b0;
    if (held) begin
      apply_step(1'b1, lim);
      commit(cyc + 7, lim);
    end
    idle(10);
    up = 1'b0;
    idle(12);
  endtask

  // monitor: adopt due expectations, then compare every instance every cycle
  always @(negedge CLK_50) begin
    logic [2:0] exp_lim;
    if (cyc >= 1) begin
      exp_lim = '0;
      if (q.size() > 0 && q[0].due < cyc) begin
        chk("sched", 0, 32'(q[0].due), 32'(cyc));
        void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].due == cyc) begin
        exp_cnt = q[0].cnt;
        exp_lim = q[0].lim;
        void'(q.pop_front());
      end
      for (int c = 0; c < 3; c++) begin
        chk("count", c, 32'(act_cnt[c]), 32'(exp_cnt[c]));
        chk("limit", c, 32'(act_lim[c]), 32'(exp_lim[c]));
        chk("seg", c, 32'(act_seg[c]), 32'({SEG_T[exp_cnt[c][7:4]], SEG_T[exp_cnt[c][3:0]]}));
      end
    end
  end

  initial begin
    for (int c = 0; c < 3; c++) mcnt[c] = 8'h00;
    idle(3);
    reset = 1'b0;
    idle(3);
    press(1'b1, 1'b0, 20);   // single press, long hold
    glitch(1'b1, 3);
    glitch(1'b0, 2);
    do_load(8'h09); press(1'b1, 1'b0, 8);
    do_load(8'h99); press(1'b1, 1'b0, 8);
    press(1'b0, 1'b1, 8);
    do_load(8'hFF); press(1'b1, 1'b0, 8);
    do_load(8'h00); press(1'b0, 1'b1, 8);
    press(1'b1, 1'b1, 8);
    do_load(8'h3A);
    press_load(1'b1, 8'h42);
    reset_mid(1'b0);
    reset_mid(1'b1);
    for (int it = 0; it < 40; it++) begin
      logic [7:0] v;
      v = 8'($urandom);
      case ($urandom_range(0, 3))
        0: v = 8'h00;
        1: v = 8'h99;
        2: v = 8'hFF;
        default: ;
      endcase
      case ($urandom_range(0, 5))
        0: press(1'b1, 1'b0, $urandom_range(6, 12));
        1: press(1'b0, 1'b1, $urandom_range(6, 12));
        2: press(1'b1, 1'b1, $urandom_range(6, 12));
        3: glitch(1'($urandom_range(0, 1)), $urandom_range(1, 3));
        4: do_load(v);
        default: press_load(1'($urandom_range(0, 1)), v);
      endcase
    end
    idle(20);
    chk("queue_drained", 0, 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
